rns_to_int_seq: RTL and testbench

Sequential mixed-radix (MRC) converter that turns a packed 4-channel RNS word into a 32-bit binary integer. It sits directly downstream of `fir_rns` and consumes its `y` output. It is the registered, handshaked replacement for the combinational RNS-to-integer path: it trades several cycles of latency for a narrow 8-bit datapath per lane. Optionally, it maps the upper half of the dynamic range to negative two's-complement results.

---
 rtl/rns_pkg.sv | 64 ++++++
 rtl/rns_sub_mul_mod.sv | 32 +++
 rtl/rns_to_int_seq.sv | 166 ++++++++++++++++
 tb/tb_rns_to_int_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared definitions for the RNS-to-integer converter.
//   - default moduli of the four lanes
//   - rns_res_t: the 8-bit residue type
//   - modinv(): constant-time modular inverse (extended Euclid)
//   - rns_range(): product of the four moduli (the dynamic range M)
//   - rns_state_e: the converter FSM states
package rns_pkg;

  localparam int unsigned M1_DEF = 233;
  localparam int unsigned M2_DEF = 239;
  localparam int unsigned M3_DEF = 241;
  localparam int unsigned M4_DEF = 251;

  typedef logic [7:0] rns_res_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_H3   = 3'd4,
    ST_H2   = 3'd5,
    ST_H1   = 3'd6,
    ST_OUT  = 3'd7
  } rns_state_e;

  // Inverse of a modulo m. Only evaluated at elaboration time, so the
  // loop bound just has to exceed the Euclid step count for 8-bit moduli.
  function automatic int unsigned modinv(input int unsigned a, input int unsigned m);
    int t;
    int newt;
    int r;
    int newr;
    int q;
    int tmp;
    t    = 0;
    newt = 1;
    r    = int'(m);
    newr = int'(a % m);
    for (int i = 0; i < 64; i++) begin
      if (newr != 0) begin
        q    = r / newr;
        tmp  = t - q * newt;
        t    = newt;
        newt = tmp;
        tmp  = r - q * newr;
        r    = newr;
        newr = tmp;
      end
    end
    if (t < 0) begin
      t = t + int'(m);
    end
    return $unsigned(t);
  endfunction

  function automatic logic [31:0] rns_range(input int unsigned m1, input int unsigned m2,
                                            input int unsigned m3, input int unsigned m4);
    logic [63:0] p;
    p = 64'(m1) * 64'(m2) * 64'(m3) * 64'(m4);
    return p[31:0];
  endfunction

endpackage

// File: rtl/rns_sub_mul_mod.sv
// Combinational modular subtract-and-scale: y_o = ((a_i - b_i) mod M) * C mod M.
//   a_i : minuend residue (already < M)
//   b_i : subtrahend residue (any 8-bit value, reduced mod M internally)
//   y_o : result residue, < M
module rns_sub_mul_mod
  import rns_pkg::*;
#(
  parameter int unsigned M = 233,
  parameter int unsigned C = 1
) (
  input  rns_res_t a_i,
  input  rns_res_t b_i,
  output rns_res_t y_o
);

  localparam logic [8:0] M9 = 9'(M);
  localparam logic [8:0] C9 = 9'(C);

  logic [8:0]  b_red;
  logic [8:0]  diff;
  logic [17:0] prod;

  always_comb begin
    // b may come from a lane with a larger modulus, so fold it first;
    // a + M - b then stays non-negative and fits in 9 bits.
    b_red = {1'b0, b_i} % M9;
    diff  = {1'b0, a_i} + M9 - b_red;
    prod  = 18'(diff) * 18'(C9);
    y_o   = 8'(prod % 18'(M9));
  end

endmodule

// File: rtl/rns_to_int_seq.sv
// Sequential mixed-radix converter: packed 4-lane RNS word -> 32-bit integer.
//   clk, reset         : single clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake, x_rns = {r4, r3, r2, r1}
//   out_valid/out_ready: output handshake for y and err
//   y                  : converted value (two's complement when SIGNED_OUT)
//   err                : some input residue was >= its modulus
// Latency is six cycles from the accepting edge; the error path goes
// straight to the output state.
module rns_to_int_seq
  import rns_pkg::*;
#(
  parameter int unsigned M1         = M1_DEF,
  parameter int unsigned M2         = M2_DEF,
  parameter int unsigned M3         = M3_DEF,
  parameter int unsigned M4         = M4_DEF,
  parameter bit          SIGNED_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_rns,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        err
);

  localparam logic [31:0] M_RANGE = rns_range(M1, M2, M3, M4);
  localparam logic [31:0] M_HALF  = 32'((64'(M_RANGE) + 64'd1) / 64'd2);

  // Inverses used by the mixed-radix digit extraction steps.
  localparam int unsigned INV1_2 = modinv(M1 % M2, M2);
  localparam int unsigned INV1_3 = modinv(M1 % M3, M3);
  localparam int unsigned INV1_4 = modinv(M1 % M4, M4);
  localparam int unsigned INV2_3 = modinv(M2 % M3, M3);
  localparam int unsigned INV2_4 = modinv(M2 % M4, M4);
  localparam int unsigned INV3_4 = modinv(M3 % M4, M4);

  rns_state_e  state_q, state_d;
  rns_res_t    r1_q, r1_d;
  rns_res_t    r2_q, r2_d;
  rns_res_t    r3_q, r3_d;
  rns_res_t    r4_q, r4_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] y_q, y_d;
  logic        err_q, err_d;

  rns_res_t s1_r2, s1_r3, s1_r4;
  rns_res_t s2_r3, s2_r4;
  rns_res_t s3_r4;

  logic lane_bad;

  // Digit a1 = r1 is removed from lanes 2..4.
  rns_sub_mul_mod #(.M(M2), .C(INV1_2)) u_s1_l2 (.a_i(r2_q), .b_i(r1_q), .y_o(s1_r2));
  rns_sub_mul_mod #(.M(M3), .C(INV1_3)) u_s1_l3 (.a_i(r3_q), .b_i(r1_q), .y_o(s1_r3));
  rns_sub_mul_mod #(.M(M4), .C(INV1_4)) u_s1_l4 (.a_i(r4_q), .b_i(r1_q), .y_o(s1_r4));
  // Digit a2 = r2 is removed from lanes 3..4.
  rns_sub_mul_mod #(.M(M3), .C(INV2_3)) u_s2_l3 (.a_i(r3_q), .b_i(r2_q), .y_o(s2_r3));
  rns_sub_mul_mod #(.M(M4), .C(INV2_4)) u_s2_l4 (.a_i(r4_q), .b_i(r2_q), .y_o(s2_r4));
  // Digit a3 = r3 is removed from lane 4, leaving a4.
  rns_sub_mul_mod #(.M(M4), .C(INV3_4)) u_s3_l4 (.a_i(r4_q), .b_i(r3_q), .y_o(s3_r4));

  assign lane_bad = (32'(x_rns[7:0])   >= M1) ||
                    (32'(x_rns[15:8])  >= M2) ||
                    (32'(x_rns[23:16]) >= M3) ||
                    (32'(x_rns[31:24]) >= M4);

  always_comb begin
    logic [31:0] acc_full;
    acc_full = 32'd0;
    state_d  = state_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    r4_d     = r4_q;
    acc_d    = acc_q;
    y_d      = y_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          r1_d  = x_rns[7:0];
          r2_d  = x_rns[15:8];
          r3_d  = x_rns[23:16];
          r4_d  = x_rns[31:24];
          acc_d = 32'd0;
          y_d   = 32'd0;
          err_d = lane_bad;
          state_d = lane_bad ? ST_OUT : ST_S1;
        end
      end
      ST_S1: begin
        r2_d    = s1_r2;
        r3_d    = s1_r3;
        r4_d    = s1_r4;
        state_d = ST_S2;
      end
      ST_S2: begin
        r3_d    = s2_r3;
        r4_d    = s2_r4;
        state_d = ST_S3;
      end
      ST_S3: begin
        r4_d    = s3_r4;
        state_d = ST_H3;
      end
      // Horner evaluation of a1 + M1*(a2 + M2*(a3 + M3*a4)); the lane
      // registers still hold the digits a1..a4 at this point.
      ST_H3: begin
        acc_d   = 32'(r4_q) * 32'(M3) + 32'(r3_q);
        state_d = ST_H2;
      end
      ST_H2: begin
        acc_d   = acc_q * 32'(M2) + 32'(r2_q);
        state_d = ST_H1;
      end
      ST_H1: begin
        acc_full = acc_q * 32'(M1) + 32'(r1_q);
        // Upper half of the range maps to negative values; the 32-bit
        // wrap of acc - M is exactly its two's-complement encoding.
        if (SIGNED_OUT && (acc_full >= M_HALF)) begin
          acc_full = acc_full - M_RANGE;
        end
        acc_d   = acc_full;
        y_d     = acc_full;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      r4_q    <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      r4_q    <= r4_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign y         = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rns_to_int_seq.sv
// Bench for rns_to_int_seq: one signed and one unsigned instance share the
// stimulus; expected results are queued at drive time and compared when
// out_valid appears.
module tb_rns_to_int_seq;

  localparam longint unsigned MM   = 64'd3368562317;
  localparam longint unsigned HALF = (MM + 64'd1) / 64'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] x_rns;
  logic        in_ready, out_valid, err;
  logic        in_ready_u, out_valid_u, err_u;
  logic [31:0] y, y_u;

  always #5 clk = ~clk;

  rns_to_int_seq #(.SIGNED_OUT(1'b1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_rns(x_rns), .out_valid(out_valid), .out_ready(out_ready), .y(y), .err(err)
  );

  rns_to_int_seq #(.SIGNED_OUT(1'b0)) u_dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u),
    .x_rns(x_rns), .out_valid(out_valid_u), .out_ready(out_ready), .y(y_u), .err(err_u)
  );

  typedef struct {
    logic [31:0] ys;
    logic [31:0] yu;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] encode(input longint unsigned v);
    return {8'(v % 251), 8'(v % 241), 8'(v % 239), 8'(v % 233)};
  endfunction

  task automatic push_val(input longint unsigned v);
    exp_t e;
    e.yu  = 32'(v);
    e.ys  = (v >= HALF) ? 32'(v - MM) : 32'(v);
    e.e   = 1'b0;
    e.lat = 6;
    sb_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.yu  = 32'd0;
    e.ys  = 32'd0;
    e.e   = 1'b1;
    e.lat = 0;
    sb_q.push_back(e);
  endtask

  // Drive one word, keep in_valid high with junk while busy (must be
  // ignored), then check the result, optional back-pressure and transfer.
  task automatic run_word(input string tag, input logic [31:0] x, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    x_rns    = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    x_rns = $urandom;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check({tag, "_sb"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_lat"}, 64'(n), 64'(e.lat));
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_y"}, 64'(y), 64'(e.ys));
      check({tag, "_err"}, 64'(err), 64'(e.e));
      check({tag, "_yu"}, 64'(y_u), 64'(e.yu));
      check({tag, "_erru"}, 64'(err_u), 64'(e.e));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_y"}, 64'(y), 64'(e.ys));
        check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    longint unsigned v;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_rns     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    reset = 1'b0;

    push_val(64'd0);          run_word("zero", 32'h0000_0000, 0);
    push_val(64'd1000);       run_word("v1000", 32'hF724_2C44, 0);
    push_val(64'd12345);      run_word("v12345", 32'h2E36_9CE5, 10);
    push_val(MM - 64'd1);     run_word("m_minus1", 32'hFAF0_EEE8, 0);
    push_val(HALF);           run_word("half", encode(HALF), 0);
    push_val(HALF - 64'd1);   run_word("half_m1", encode(HALF - 64'd1), 0);
    push_err();               run_word("err_l0", 32'hF724_2CFF, 2);
    push_err();               run_word("err_l3", 32'hFB00_0000, 0);
    push_val(64'd7);          run_word("after_err", encode(64'd7), 0);

    for (int i = 0; i < 8; i++) begin
      v = 64'($urandom) % MM;
      push_val(v);
      run_word("rand", encode(v), i % 3);
    end

    // Reset while in H2: the conversion must vanish without an output.
    x_rns    = 32'hF724_2C44;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_h2_in_ready", 64'(in_ready), 64'd1);
    check("rst_h2_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_h2_discard", 64'(out_valid), 64'd0);
    end
    push_val(64'd1000);       run_word("post_rst", 32'hF724_2C44, 0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
